// File: rtl/uart_image_loader_pkg.sv
// Shared definitions for the UART image loader: FSM state encoding and the
// bit-timing helpers used to size the per-bit cycle counter.
package uart_image_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WRITE,
    S_DONE
  } state_t;

  // Clock cycles spent on one UART bit (integer division, floor).
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Width of the per-bit cycle counter.
  function automatic int cnt_width(input int cpb);
    return $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_image_loader_rx_sync.sv
// Two-flop synchronizer for the asynchronous UART line plus a falling-edge
// detector on the synchronized value. All flops reset to the idle level (1).
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain and one-cycle history for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx_s = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_image_loader.sv
// UART image loader: receives an image byte-stream over UART and writes each
// byte sequentially into DRAM, raising end_receive once IMG_BYTES are stored.
// Build option: define UART_LOADER_PARITY_EN for 8E1 framing with a sticky
// parity_err output; otherwise 8N1 framing.
module uart_image_loader
  import uart_image_loader_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int IMG_BYTES = 65536,
  parameter int ADDR_W    = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en_com,
  input  logic              rx,
  input  logic              rx_clr,
  output logic [ADDR_W-1:0] rx_addr,
  output logic [7:0]        rx_data,
  output logic              rx_wren,
  output logic              end_receive,
`ifdef UART_LOADER_PARITY_EN
  output logic              frame_err,
  output logic              parity_err
`else
  output logic              frame_err
`endif
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = cnt_width(CPB);

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(IMG_BYTES - 1);

  logic w_rx_s;
  logic w_fall;

  state_t            r_state,   w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic [2:0]        r_bit,     w_bit_nxt;
  logic [7:0]        r_shreg,   w_shreg_nxt;
  logic [7:0]        r_data,    w_data_nxt;
  logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
  logic              r_end,     w_end_nxt;
  logic              r_ferr,    w_ferr_nxt;
`ifdef UART_LOADER_PARITY_EN
  logic              r_perr,    w_perr_nxt;
`endif

  uart_rx_sync u_sync (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_rx    (rx),
    .o_rx_s  (w_rx_s),
    .o_fall  (w_fall)
  );

  // State and datapath registers; rx_clr restores reset values synchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_end   <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else if (rx_clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_end   <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_data  <= w_data_nxt;
      r_addr  <= w_addr_nxt;
      r_end   <= w_end_nxt;
      r_ferr  <= w_ferr_nxt;
`ifdef UART_LOADER_PARITY_EN
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  // Next-state and datapath updates for the receive FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data;
    w_addr_nxt  = r_addr;
    w_end_nxt   = r_end;
    w_ferr_nxt  = r_ferr;
`ifdef UART_LOADER_PARITY_EN
    w_perr_nxt  = r_perr;
`endif

    // Losing the enable aborts any frame in flight; the address is untouched
    // so the next good byte rewrites the same location.
    if (!en_com && (r_state != S_DONE)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_bit_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall && !r_end) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = '0;
          end
        end

        S_START: begin
          if (r_cnt == CNT_HALF) begin
            w_cnt_nxt = '0;
            w_bit_nxt = '0;
            w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == CNT_FULL) begin
            w_cnt_nxt   = '0;
            w_shreg_nxt = {w_rx_s, r_shreg[7:1]};
            if (r_bit == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end

`ifdef UART_LOADER_PARITY_EN
        S_PARITY: begin
          if (r_cnt == CNT_FULL) begin
            w_cnt_nxt = '0;
            if (^{r_shreg, w_rx_s}) begin
              w_perr_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_STOP;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (r_cnt == CNT_FULL) begin
            w_cnt_nxt = '0;
            if (w_rx_s) begin
              w_data_nxt  = r_shreg;
              w_state_nxt = S_WRITE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end

        S_WRITE: begin
          if (r_addr == ADDR_MAX) begin
            w_end_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_addr_nxt  = r_addr + 1'b1;
            w_state_nxt = S_IDLE;
          end
        end

        S_DONE: begin
          w_state_nxt = S_DONE;
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign rx_addr     = r_addr;
  assign rx_data     = r_data;
  assign rx_wren     = (r_state == S_WRITE) && en_com;
  assign end_receive = r_end;
  assign frame_err   = r_ferr;
`ifdef UART_LOADER_PARITY_EN
  assign parity_err  = r_perr;
`endif

endmodule

// File: tb/tb_uart_image_loader.sv
// Scoreboard bench for uart_image_loader (CLKS_PER_BIT=10, IMG_BYTES=4).
module tb_uart_image_loader;

  localparam int ADDR_W = 20;
  localparam int IMG    = 4;
  localparam int BITC   = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en_com;
  logic              rx;
  logic              rx_clr;
  logic [ADDR_W-1:0] rx_addr;
  logic [7:0]        rx_data;
  logic              rx_wren;
  logic              end_receive;
  logic              frame_err;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_wr   = 0;
  int   last_wr = 0;
  int   t_fall = 0;
  bit   chk_end_next = 1'b0;

  uart_image_loader #(
    .CLK_FREQ  (1000),
    .BAUD      (100),
    .IMG_BYTES (IMG),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .en_com      (en_com),
    .rx          (rx),
    .rx_clr      (rx_clr),
    .rx_addr     (rx_addr),
    .rx_data     (rx_data),
    .rx_wren     (rx_wren),
    .end_receive (end_receive),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (chk_end_next) begin
      chk_end_next = 1'b0;
      n_chk++;
      if (end_receive !== 1'b1) begin
        n_fail++;
        $display("FAIL end_after_last_write: got %b want 1", end_receive);
      end
    end
    if (rx_wren === 1'b1) begin
      n_wr++;
      last_wr = cyc;
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%02h, none expected", rx_addr, rx_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rx_addr !== e.a || rx_data !== e.d) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%02h want addr=%0d data=%02h",
                   rx_addr, rx_data, e.a, e.d);
        end
        if (e.a == ADDR_W'(IMG - 1)) chk_end_next = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    t_fall = cyc;
    hold(1'b0, BITC);
    for (int i = 0; i < 8; i++) hold(b[i], BITC);
    hold(stop, BITC);
    hold(1'b1, 6);
  endtask

  task automatic expect_wr(input int a, input logic [7:0] d);
    exp_t e;
    e.a = ADDR_W'(a);
    e.d = d;
    q.push_back(e);
  endtask

  task automatic pulse_clr();
    rx_clr = 1'b1;
    idle(1);
    rx_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int lat;
    reset_n = 1'b0;
    en_com  = 1'b1;
    rx      = 1'b1;
    rx_clr  = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(2);

    chk("reset_addr", rx_addr, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_wren", rx_wren, 0);
    chk("reset_end", end_receive, 0);
    chk("reset_ferr", frame_err, 0);

    // Single byte, latency from the start-bit falling edge
    wr0 = n_wr;
    expect_wr(0, 8'hA5);
    send(8'hA5, 1'b1);
    idle(4);
    lat = last_wr - t_fall;
    chk("a5_pulse_count", n_wr - wr0, 1);
    if (lat < 95 || lat > 100) $display("  latency observed = %0d cycles", lat);
    chk("a5_latency_in_window", (lat >= 95 && lat <= 100), 1);
    chk("a5_addr_after", rx_addr, 1);

    // Fill the whole image, then extra traffic is ignored
    pulse_clr();
    wr0 = n_wr;
    for (int i = 0; i < IMG; i++) begin
      expect_wr(i, 8'(i + 1));
      send(8'(i + 1), 1'b1);
    end
    chk("fill_end", end_receive, 1);
    send(8'hFF, 1'b1);
    idle(4);
    chk("fill_writes", n_wr - wr0, 4);
    chk("done_addr_held", rx_addr, 3);
    chk("done_end_held", end_receive, 1);

    // Framing error drops the byte, next good byte reuses the address
    pulse_clr();
    send(8'h3C, 1'b0);
    idle(4);
    chk("ferr_set", frame_err, 1);
    chk("ferr_addr", rx_addr, 0);
    expect_wr(0, 8'h55);
    send(8'h55, 1'b1);
    idle(2);
    chk("ferr_next_addr", rx_addr, 1);
    chk("ferr_sticky", frame_err, 1);

    // Short glitch rejected at the start-bit midpoint
    hold(1'b0, 3);
    hold(1'b1, 30);
    chk("glitch_addr", rx_addr, 1);
    expect_wr(1, 8'h12);
    send(8'h12, 1'b1);
    idle(2);
    chk("glitch_next_addr", rx_addr, 2);

    // Enable dropped mid-frame: partial byte discarded
    hold(1'b0, BITC);
    for (int i = 0; i < 4; i++) hold(i == 0, BITC);
    rx = 1'b1;
    en_com = 1'b0;
    idle(5);
    en_com = 1'b1;
    idle(20);
    chk("abort_addr", rx_addr, 2);
    expect_wr(2, 8'h77);
    send(8'h77, 1'b1);
    idle(2);
    chk("abort_next_addr", rx_addr, 3);

    // Asynchronous reset mid-frame
    hold(1'b0, 30);
    reset_n = 1'b0;
    #1;
    chk("areset_addr", rx_addr, 0);
    chk("areset_data", rx_data, 0);
    chk("areset_wren", rx_wren, 0);
    chk("areset_end", end_receive, 0);
    chk("areset_ferr", frame_err, 0);
    rx = 1'b1;
    idle(2);
    reset_n = 1'b1;
    idle(3);

    // rx_clr after completion restarts the load
    send(8'h3C, 1'b0);
    idle(2);
    for (int i = 0; i < IMG; i++) begin
      expect_wr(i, 8'(8'h10 * (i + 1)));
      send(8'(8'h10 * (i + 1)), 1'b1);
    end
    chk("refill_end", end_receive, 1);
    chk("refill_ferr", frame_err, 1);
    pulse_clr();
    chk("clr_end", end_receive, 0);
    chk("clr_addr", rx_addr, 0);
    chk("clr_ferr", frame_err, 0);
    expect_wr(0, 8'h9A);
    send(8'h9A, 1'b1);
    idle(2);
    chk("clr_next_addr", rx_addr, 1);

    idle(5);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_image_loader.md
Name: uart_image_loader

Overview:
- Upstream stage of the downsampling processor.
- Receives the raw image byte-stream from the PC over a UART line and writes each byte sequentially into data memory (DRAM) through the receive address/data/write-enable path.
- Asserts end_receive once IMG_BYTES bytes are stored; the main controller then leaves the receive state.
- Active only while the main controller grants the communication enable en_com.

Parameters:
- CLK_FREQ, 50000000: clock frequency in Hz.
- BAUD, 115200: UART bit rate.
- IMG_BYTES, 65536: number of bytes in one image (must be <= 2**ADDR_W).
- ADDR_W, 20: DRAM address width.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- en_com  in  1  receive enable from main controller.
- rx  in  1  UART serial input; idle high; asynchronous to clock.
- rx_clr  in  1  synchronous clear; restarts the image load.
- rx_addr  out  ADDR_W  DRAM write address.
- rx_data  out  8  DRAM write data.
- rx_wren  out  1  DRAM write strobe, one cycle per byte.
- end_receive  out  1  image fully stored; level signal.
- frame_err  out  1  sticky; a stop bit sampled low.

Behaviour:
- Derived constant: CLKS_PER_BIT = CLK_FREQ/BAUD (integer division). Must be >= 4. Bit counter width is clog2(CLKS_PER_BIT).
- rx passes through a 2-flop synchronizer with reset value 1. All sampling uses the synchronized value rx_s.
- Reset (async, reset_n=0): state IDLE; rx_addr=0, rx_data=0, rx_wren=0, end_receive=0, frame_err=0; shift register, bit counter and cycle counter all 0.
- rx_clr=1: overrides everything except reset, at the next edge. Same values as reset, except synchronizer contents are kept.
- FSM states:
  - IDLE: on a falling edge of rx_s with en_com=1 and end_receive=0 -> START; cycle counter cleared.
  - START: count CLKS_PER_BIT/2 cycles. At the midpoint, rx_s=0 -> DATA with counters cleared; rx_s=1 (glitch) -> IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s and shift it in LSB-first. After the 8th sample -> STOP (or PARITY, see feature).
  - STOP: after CLKS_PER_BIT cycles, sample rx_s. If 1 -> WRITE. If 0 -> set frame_err, drop the byte, -> IDLE.
  - WRITE: single cycle. rx_wren=1, rx_data=assembled byte, rx_addr=current address. Next edge: if rx_addr==IMG_BYTES-1 -> DONE with end_receive=1 and rx_addr held; otherwise rx_addr+1 -> IDLE.
  - DONE: end_receive held 1; all further rx traffic ignored. Leaves only on rx_clr or reset.
- Latency: rx_wren rises on the cycle after the stop-bit midpoint sample.
- en_com=0 in any non-DONE state: abort -> IDLE. The partial byte is discarded and rx_addr is unchanged; the same address is rewritten by the next good byte.
- rx_wren is never asserted outside WRITE, and never while en_com=0 on that cycle.
- rx_addr never exceeds IMG_BYTES-1. There is no wrap-around.
- frame_err does not stop the load. It clears only on rx_clr or reset.

Optional Feature:
- Macro: UART_LOADER_PARITY_EN.
- Defined: an even-parity bit follows bit 7, and the FSM adds a PARITY state sampled after CLKS_PER_BIT cycles. A parity mismatch drops the byte and sets an extra sticky output parity_err (1 bit, reset 0, cleared by rx_clr).
- Undefined: 8N1 framing only; no PARITY state and no parity_err port.

Decomposition:
- Shared package/include (loader_defs): state encodings (IDLE, START, DATA, PARITY, STOP, WRITE, DONE) and the CLKS_PER_BIT/clog2 constant function.
- One natural sub-module, uart_rx_sync: 2-flop synchronizer plus falling-edge detect, with reset value 1 under reset_n.

Test Plan (CLK_FREQ=1000, BAUD=100 -> CLKS_PER_BIT=10, IMG_BYTES=4):
- en_com=1, send 0xA5 8N1 -> exactly one rx_wren pulse, about 97 cycles after the rx falling edge (sync + 9.5 bits), with rx_data=0xA5, rx_addr=0; rx_addr=1 afterwards.
- Send 0x01,0x02,0x03,0x04, then 0xFF -> four writes to addresses 0..3 with the matching data; end_receive=1 the cycle after the 4th write; 0xFF produces no write; rx_addr stays 3.
- Send 0x3C with a low stop bit -> frame_err=1, no rx_wren, rx_addr unchanged; the next good byte 0x55 writes to the same address.
- 3-cycle low glitch on rx -> START rejects it at the midpoint; no write; FSM returns to IDLE and a following 0x12 is received correctly.
- Drop en_com after 4 data bits, restore it, send 0x77 -> the partial byte is not written; 0x77 is written at the unchanged address. Separately, pulse reset_n low mid-frame -> all outputs 0 immediately.
- After end_receive=1, pulse rx_clr for one cycle -> end_receive=0, rx_addr=0, frame_err=0; a new byte 0x9A writes to address 0.
